// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage.
// Format selects and handshake state encoding.
package imm_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bundle for the immediate-generation stage.
// slave = the stage, master = upstream/downstream environment.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_inst,
        input  in_sel,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_tag,
        output out_err
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_inst,
        output in_sel,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_tag,
        input  out_err
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder.
// Builds a 32-bit value, then sign-extends it to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  logic [2:0]      i_sel,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    localparam bit IS64 = (XLEN == 64);

    logic        w_s;
    logic [31:0] w_imm32;
    logic        w_unused;

    assign w_s      = i_inst[31];
    assign w_unused = ^i_inst[6:0];

    // Format mux; zero-extended fields keep bit 31 clear so the
    // final sign extension leaves them untouched.
    always_comb begin
        w_imm32 = '0;
        o_err   = 1'b0;
        unique case (i_sel)
            IMM_I: w_imm32 = {{20{w_s}}, i_inst[31:20]};
            IMM_S: w_imm32 = {{20{w_s}}, i_inst[31:25],
                              i_inst[11:7]};
            IMM_B: w_imm32 = {{19{w_s}}, i_inst[31], i_inst[7],
                              i_inst[30:25], i_inst[11:8], 1'b0};
            IMM_U: w_imm32 = {i_inst[31:12], 12'b0};
            IMM_J: w_imm32 = {{11{w_s}}, i_inst[31],
                              i_inst[19:12], i_inst[20],
                              i_inst[30:21], 1'b0};
            IMM_Z: w_imm32 = {27'b0, i_inst[19:15]};
            IMM_SH: begin
                if (IS64) begin
                    w_imm32 = {26'b0, i_inst[25:20]};
                end else begin
                    w_imm32 = {27'b0, i_inst[24:20]};
                end
            end
            default: begin
                w_imm32 = '0;
                o_err   = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_narrow
            assign o_imm = w_imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage between decode and execute.
// Out slot plus one skid entry; in_ready depends only on state.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    imm_gen_stage_if.slave  bus
);

    state_e           r_state;
    state_e           w_state_nxt;

    logic [XLEN-1:0]  r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_err;

    logic [XLEN-1:0]  w_dec_imm;
    logic             w_dec_err;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_promote;

    imm_decode #(
        .XLEN (XLEN)
    ) u_dec (
        .i_inst (bus.in_inst),
        .i_sel  (bus.in_sel),
        .o_imm  (w_dec_imm),
        .o_err  (w_dec_err)
    );

    assign w_in_ready  = (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_imm   = r_out_imm;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_err   = r_out_err;

    // Next state and data-path load strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_promote   = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && !w_out_fire) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_in_fire && w_out_fire) begin
                    w_load_out  = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_promote   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register; reset wins over flush, both empty the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Out slot: loads on direct accept or skid promotion only.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_imm <= '0;
            r_out_tag <= '0;
            r_out_err <= 1'b0;
        end else if (w_load_out) begin
            r_out_imm <= w_dec_imm;
            r_out_tag <= bus.in_tag;
            r_out_err <= w_dec_err;
        end else if (w_promote) begin
            r_out_imm <= r_skid_imm;
            r_out_tag <= r_skid_tag;
            r_out_err <= r_skid_err;
        end
    end

    // Skid slot: holds the younger entry while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_err <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_dec_imm;
            r_skid_tag <= bus.in_tag;
            r_skid_err <= w_dec_err;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage.
// Covers decode, XLEN=64, backpressure, throughput, flush, reset.
module tb_imm_gen_stage;
    import imm_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    logic flush64;

    int n_tests;
    int n_fail;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    imm_gen_stage #(
        .XLEN  (32),
        .TAG_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus32)
    );

    imm_gen_stage #(
        .XLEN  (64),
        .TAG_W (32)
    ) dut64 (
        .clk   (clk),
        .reset (reset),
        .flush (flush64),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive32(input logic [31:0] inst,
                           input logic [2:0] sel,
                           input logic [31:0] tag);
        bus32.in_valid = 1'b1;
        bus32.in_inst  = inst;
        bus32.in_sel   = sel;
        bus32.in_tag   = tag;
        @(negedge clk);
        bus32.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid got %b want 0", bus32.out_valid);
        end
        n_tests++;
        if (bus32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready got %b want 1", bus32.in_ready);
        end
        n_tests++;
        if (bus32.out_imm !== 32'h0 || bus32.out_tag !== 32'h0
            || bus32.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_data got imm=%h tag=%h err=%b want 0",
                     bus32.out_imm, bus32.out_tag, bus32.out_err);
        end
    endtask

    task automatic test_formats;
        logic [31:0] v_inst [5];
        logic [2:0]  v_sel  [5];
        logic [31:0] v_exp  [5];
        v_inst = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                   32'h123450B7, 32'h010000EF};
        v_sel  = '{IMM_I, IMM_S, IMM_B, IMM_U, IMM_J};
        v_exp  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                   32'h12345000, 32'h00000010};
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive32(v_inst[i], v_sel[i], 32'(i + 16));
            n_tests++;
            if (bus32.out_valid !== 1'b1
                || bus32.out_imm !== v_exp[i]
                || bus32.out_err !== 1'b0
                || bus32.out_tag !== 32'(i + 16)) begin
                n_fail++;
                $display("FAIL fmt%0d got v=%b imm=%h err=%b tag=%0d want v=1 imm=%h err=0 tag=%0d",
                         i, bus32.out_valid, bus32.out_imm,
                         bus32.out_err, bus32.out_tag, v_exp[i], i + 16);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_special;
        logic [31:0] v_inst [3];
        logic [2:0]  v_sel  [3];
        logic [31:0] v_exp  [3];
        logic        v_err  [3];
        v_inst = '{32'h30529073, 32'h41F0D093, 32'hFFFFFFFF};
        v_sel  = '{IMM_Z, IMM_SH, IMM_ILL};
        v_exp  = '{32'h00000005, 32'h0000001F, 32'h00000000};
        v_err  = '{1'b0, 1'b0, 1'b1};
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive32(v_inst[i], v_sel[i], 32'(i + 32));
            n_tests++;
            if (bus32.out_valid !== 1'b1
                || bus32.out_imm !== v_exp[i]
                || bus32.out_err !== v_err[i]) begin
                n_fail++;
                $display("FAIL special%0d got v=%b imm=%h err=%b want v=1 imm=%h err=%b",
                         i, bus32.out_valid, bus32.out_imm,
                         bus32.out_err, v_exp[i], v_err[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_xlen64;
        logic [31:0] v_inst [2];
        logic [2:0]  v_sel  [2];
        logic [63:0] v_exp  [2];
        v_inst = '{32'hFFF00093, 32'h800000B7};
        v_sel  = '{IMM_I, IMM_U};
        v_exp  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000};
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus64.in_valid = 1'b1;
            bus64.in_inst  = v_inst[i];
            bus64.in_sel   = v_sel[i];
            bus64.in_tag   = 32'(i + 48);
            @(negedge clk);
            bus64.in_valid = 1'b0;
            n_tests++;
            if (bus64.out_valid !== 1'b1
                || bus64.out_imm !== v_exp[i]
                || bus64.out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL x64_%0d got v=%b imm=%h err=%b want v=1 imm=%h err=0",
                         i, bus64.out_valid, bus64.out_imm,
                         bus64.out_err, v_exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_tag;
        bus32.out_ready = 1'b0;
        drive32(32'h00100013, IMM_I, 32'd1);
        n_tests++;
        if (bus32.in_ready !== 1'b1 || bus32.out_tag !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_first got rdy=%b tag=%0d want rdy=1 tag=1",
                     bus32.in_ready, bus32.out_tag);
        end
        drive32(32'h00200013, IMM_I, 32'd2);
        n_tests++;
        if (bus32.in_ready !== 1'b0 || bus32.out_tag !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_full got rdy=%b tag=%0d want rdy=0 tag=1",
                     bus32.in_ready, bus32.out_tag);
        end
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h00300013;
        bus32.in_sel   = IMM_I;
        bus32.in_tag   = 32'd3;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1
            || bus32.out_tag !== 32'd1 || bus32.out_imm !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_stall got rdy=%b v=%b tag=%0d imm=%h want rdy=0 v=1 tag=1 imm=1",
                     bus32.in_ready, bus32.out_valid,
                     bus32.out_tag, bus32.out_imm);
        end
        bus32.out_ready = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            exp_tag = 32'(i);
            n_tests++;
            if (bus32.out_valid !== 1'b1 || bus32.out_tag !== exp_tag
                || bus32.out_imm !== exp_tag) begin
                n_fail++;
                $display("FAIL bp_drain%0d got v=%b tag=%0d imm=%h want v=1 tag=%0d",
                         i, bus32.out_valid, bus32.out_tag,
                         bus32.out_imm, exp_tag);
            end
            if (i == 3) bus32.in_valid = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty got v=%b want 0", bus32.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int n_acc;
        bus32.out_ready = 1'b1;
        drive32(32'h06400013, IMM_I, 32'd100);
        n_acc = 0;
        for (int i = 1; i <= 10; i++) begin
            if (bus32.in_ready === 1'b1) n_acc++;
            bus32.in_valid = 1'b1;
            bus32.in_inst  = 32'(100 + i) << 20;
            bus32.in_sel   = IMM_I;
            bus32.in_tag   = 32'(100 + i);
            @(negedge clk);
            n_tests++;
            if (bus32.out_valid !== 1'b1
                || bus32.out_tag !== 32'(100 + i)
                || bus32.out_imm !== 32'(100 + i)) begin
                n_fail++;
                $display("FAIL b2b%0d got v=%b tag=%0d imm=%h want v=1 tag=%0d",
                         i, bus32.out_valid, bus32.out_tag,
                         bus32.out_imm, 100 + i);
            end
        end
        bus32.in_valid = 1'b0;
        n_tests++;
        if (n_acc != 10 || bus32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accepts got %0d rdy=%b want 10 rdy=1",
                     n_acc, bus32.in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty got v=%b want 0", bus32.out_valid);
        end
    endtask

    task automatic fill_two;
        bus32.out_ready = 1'b0;
        drive32(32'h00500013, IMM_I, 32'd5);
        drive32(32'h00600013, IMM_I, 32'd6);
    endtask

    task automatic test_flush;
        fill_two();
        n_tests++;
        if (bus32.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_pre got rdy=%b want 0", bus32.in_ready);
        end
        flush          = 1'b1;
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h00900013;
        bus32.in_sel   = IMM_I;
        bus32.in_tag   = 32'd9;
        @(negedge clk);
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        n_tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1
            || bus32.out_imm !== 32'h0 || bus32.out_tag !== 32'h0) begin
            n_fail++;
            $display("FAIL fl_post got v=%b rdy=%b imm=%h tag=%0d want v=0 rdy=1 imm=0 tag=0",
                     bus32.out_valid, bus32.in_ready,
                     bus32.out_imm, bus32.out_tag);
        end
        @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_noacc got v=%b want 0", bus32.out_valid);
        end
    endtask

    task automatic test_reset_mid;
        fill_two();
        reset          = 1'b1;
        flush          = 1'b1;
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'hFFF00093;
        bus32.in_sel   = IMM_ILL;
        bus32.in_tag   = 32'd7;
        @(negedge clk);
        reset          = 1'b0;
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        n_tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1
            || bus32.out_imm !== 32'h0 || bus32.out_tag !== 32'h0
            || bus32.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_post got v=%b rdy=%b imm=%h tag=%0d err=%b want all 0 rdy=1",
                     bus32.out_valid, bus32.in_ready, bus32.out_imm,
                     bus32.out_tag, bus32.out_err);
        end
        @(negedge clk);
        n_tests++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_noacc got v=%b want 0", bus32.out_valid);
        end
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        flush           = 1'b0;
        flush64         = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.in_inst   = '0;
        bus32.in_sel    = '0;
        bus32.in_tag    = '0;
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_inst   = '0;
        bus64.in_sel    = '0;
        bus64.in_tag    = '0;
        bus64.out_ready = 1'b1;
        test_reset();
        test_formats();
        test_special();
        test_xlen64();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
